mlp_cpu_top: RTL and testbench
==============================

# mlp_cpu_top

Top level of the small 8-bit processor: one 256-byte unified instruction/data memory plus an execution unit (register file, ALU, zero flag, program counter, control FSM). It runs the 16-bit-instruction ISA defined in the shared ISA package. It has no external data ports. Program and data are preloaded hierarchically into memory before reset is released, and results are observed through the memory and register contents.

## Interface
- Parameters: none. Sizes are fixed: 8-bit data, 8-bit addresses, 16 × 8-bit registers.
- Ports:
- `clk  input  1  system clock; all state changes on its rising edge`
- `reset  input  1  synchronous, active-high reset`
- Hierarchy (used by benches and loggers):
  - memory instance `memory`, containing array `memory[0:255]` of 8 bits.
  - execution unit instance `u_exec`, containing register file `registers`.
  - each register is an instance `r0`..`r15` with an 8-bit value `bits`.

## Operation
- Instruction format: 2 bytes, big-endian, at an even address.
  - byte0 = {opcode[3:0], rd[3:0]}.
  - byte1 = imm8/addr8 or {rs[3:0], rt[3:0]}.
- Opcodes (isa_pkg):
  - NOP=0: no effect.
  - MOVIR=1: rd←imm.
  - LOAD=2: rd←mem[addr].
  - STORE=3: mem[addr]←rd.
  - ADDRR=4: rd←rs+rt.
  - SUBRR=5: rd←rs−rt.
  - ANDRR=6: rd←rs&rt.
  - ORRR=7: rd←rs|rt.
  - XORRR=8: rd←rs^rt.
  - JMPI=9: PC←addr.
  - JZI=10: if Z, PC←addr.
  - JNZI=11: if !Z, PC←addr.
  - HALT=15: stop fetching.
  - Opcodes 12–14 execute as NOP.
- Arithmetic: 8-bit modulo, carry and borrow discarded.
- Zero flag Z:
  - Updated only by ADDRR, SUBRR, ANDRR, ORRR and XORRR: Z = (result == 0).
  - Every other instruction leaves Z unchanged.
- In jumps, rd is ignored. In MOVIR/LOAD/STORE, byte1 is the immediate or address.
- Code may modify itself: a STORE into a not-yet-fetched instruction byte takes effect when that byte is fetched.
- HALT: the FSM stays in HALTED until reset. Registers and memory are frozen.

## Timing
- Memory: combinational read, synchronous write (write on the EXEC edge).
- FSM, 3 cycles per instruction:
  - FETCH0: IR_hi←mem[PC].
  - FETCH1: IR_lo←mem[PC+1], PC←PC+2.
  - EXEC: register/memory/flag writeback or PC load, then → FETCH0.
- HALT goes EXEC → HALTED.
- PC is 8 bits and wraps 0xFE→0x00. It stays even unless a jump targets an odd address; the jump is taken as given, with no alignment check.
- Reset values:
  - PC=0, Z=0, IR=0x0000, state=FETCH0, r0..r15=0.
  - Memory is NOT reset, so preloaded contents survive reset.
- Reset asserted mid-instruction:
  - Any pending writeback is abandoned.
  - Fetch restarts at address 0 on the first edge after reset deasserts.
- A register written in EXEC is visible to the next instruction (no hazards, since the design is not pipelined).
- Reading and writing the same register in one instruction (e.g. ADDRR r1,r1,r0) uses the old value as the operand.

## Structure
- `isa_pkg` holds:
  - opcode enum (4-bit) and FSM state enum.
  - instruction field typedef (opcode, rd, byte1).
  - constants for memory size 256 and register count 16.
- Sub-modules:
  - `memory`: 256×8 array with write port.
  - `execution_unit`: FSM, PC, IR, Z, ALU.
  - `register_file`: instances `r0`..`r15` of an 8-bit register module exposing `bits`.

## Test plan
- Memory all NOP (0x00), reset 1 cycle:
  - PC reads 0,2,4…, wraps after 0xFE.
  - Registers stay 0.
- MOVIR r0,1; MOVIR r1,16; STORE r1,16:
  - after 9 cycles, r0=1, r1=16, mem[16]=16.
- ADDRR r1,r1,r0 with r1=16, r0=1:
  - r1=17, Z=0.
- SUBRR r2,r0,r0:
  - r2=0, Z=1.
  - then JZI 0x20 jumps to 0x20; JNZI falls through.
- Self-modification: STORE r1,7 with r1=0x30, where byte 7 is the address byte of a STORE at 6:
  - re-executing that STORE writes mem[0x30].
- Reset asserted during EXEC of STORE:
  - memory unchanged.
  - PC=0, registers 0; execution restarts at 0.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, FSM states, instruction fields, memory/register sizes and the ALU helper
package isa_pkg;
  localparam int MEM_SIZE = 256;
  localparam int REG_COUNT = 16;
  typedef enum logic [3:0] {
    NOP = 4'd0, MOVIR = 4'd1, LOAD = 4'd2, STORE = 4'd3, ADDRR = 4'd4, SUBRR = 4'd5, ANDRR = 4'd6,
    ORRR = 4'd7, XORRR = 4'd8, JMPI = 4'd9, JZI = 4'd10, JNZI = 4'd11, HALT = 4'd15
  } opcode_e;
  typedef enum logic [1:0] {FETCH0, FETCH1, EXEC, HALTED} state_e;
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [7:0] byte1;
  } instr_t;
  function automatic logic [7:0] alu(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    return op == ADDRR ? a + b : op == SUBRR ? a - b : op == ANDRR ? a & b : op == ORRR ? a | b : a ^ b;
  endfunction
endpackage

// File: rtl/mlp_cpu_if.sv
// mlp_cpu_if: memory bus (addr, wdata, we from the execution unit; rdata from memory)
interface mlp_cpu_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic we;
  modport master (output addr, wdata, we, input rdata);
  modport slave (input addr, wdata, we, output rdata);
endinterface

// File: rtl/execution_unit.sv
// execution_unit: fetch/exec FSM, PC, IR, zero flag, ALU and register file; ports clk, reset, bus (master)
module execution_unit
  import isa_pkg::*;
(
  input logic clk,
  input logic reset,
  mlp_cpu_if.master bus
);
  state_e state, nxt;
  logic [7:0] pc;
  logic [15:0] ir;
  logic z;
  instr_t ins;
  logic [7:0] qd, qs, qt, res, wd;
  logic rwe, alu_op, take;
  assign ins = instr_t'(ir);
  assign res = alu(ins.opcode, qs, qt);
  register_file registers (
    .clk, .reset, .we(rwe), .wa(ins.rd), .wd, .ra(ins.rd), .rb(ins.byte1[7:4]), .rc(ins.byte1[3:0]),
    .qa(qd), .qb(qs), .qc(qt)
  );
  // writes are gated by reset so a reset landing on EXEC abandons the writeback
  always_comb begin
    alu_op = ins.opcode inside {ADDRR, SUBRR, ANDRR, ORRR, XORRR};
    take = ins.opcode == JMPI || (ins.opcode == JZI && z) || (ins.opcode == JNZI && !z);
    rwe = state == EXEC && !reset && (alu_op || ins.opcode == MOVIR || ins.opcode == LOAD);
    wd = ins.opcode == MOVIR ? ins.byte1 : ins.opcode == LOAD ? bus.rdata : res;
    bus.addr = state == FETCH0 ? pc : state == FETCH1 ? pc + 8'd1 : ins.byte1;
    bus.wdata = qd;
    bus.we = state == EXEC && !reset && ins.opcode == STORE;
    nxt = state == FETCH0 ? FETCH1 : state == FETCH1 ? EXEC :
          state == EXEC ? (ins.opcode == HALT ? HALTED : FETCH0) : HALTED;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH0;
      pc <= 8'd0;
      ir <= 16'd0;
      z <= 1'b0;
    end else begin
      state <= nxt;
      if (state == FETCH0) ir[15:8] <= bus.rdata;
      if (state == FETCH1) begin
        ir[7:0] <= bus.rdata;
        pc <= pc + 8'd2;
      end
      if (state == EXEC && alu_op) z <= res == 8'd0;
      if (state == EXEC && take) pc <= ins.byte1;
    end
endmodule

// File: rtl/memory.sv
// memory: 256x8 unified memory, combinational read, synchronous write; ports clk, bus (slave); never reset
module memory
  import isa_pkg::*;
(
  input logic clk,
  mlp_cpu_if.slave bus
);
  logic [7:0] memory [0:MEM_SIZE-1];
  assign bus.rdata = memory[bus.addr];
  always_ff @(posedge clk)
    if (bus.we) memory[bus.addr] <= bus.wdata;
endmodule

// File: rtl/register8.sv
// register8: 8-bit register with write enable; ports clk, reset, we, d, bits
module register8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] bits
);
  always_ff @(posedge clk)
    bits <= reset ? 8'd0 : we ? d : bits;
endmodule

// File: rtl/register_file.sv
// register_file: 16x8 registers r0..r15, one write port (we, wa, wd), three read ports (ra/qa, rb/qb, rc/qc)
module register_file
  import isa_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] wa,
  input  logic [7:0] wd,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic [7:0] qa,
  output logic [7:0] qb,
  output logic [7:0] qc
);
  logic [7:0] v [REG_COUNT];
  register8 r0  (.clk, .reset, .we(we && wa == 4'd0),  .d(wd), .bits(v[0]));
  register8 r1  (.clk, .reset, .we(we && wa == 4'd1),  .d(wd), .bits(v[1]));
  register8 r2  (.clk, .reset, .we(we && wa == 4'd2),  .d(wd), .bits(v[2]));
  register8 r3  (.clk, .reset, .we(we && wa == 4'd3),  .d(wd), .bits(v[3]));
  register8 r4  (.clk, .reset, .we(we && wa == 4'd4),  .d(wd), .bits(v[4]));
  register8 r5  (.clk, .reset, .we(we && wa == 4'd5),  .d(wd), .bits(v[5]));
  register8 r6  (.clk, .reset, .we(we && wa == 4'd6),  .d(wd), .bits(v[6]));
  register8 r7  (.clk, .reset, .we(we && wa == 4'd7),  .d(wd), .bits(v[7]));
  register8 r8  (.clk, .reset, .we(we && wa == 4'd8),  .d(wd), .bits(v[8]));
  register8 r9  (.clk, .reset, .we(we && wa == 4'd9),  .d(wd), .bits(v[9]));
  register8 r10 (.clk, .reset, .we(we && wa == 4'd10), .d(wd), .bits(v[10]));
  register8 r11 (.clk, .reset, .we(we && wa == 4'd11), .d(wd), .bits(v[11]));
  register8 r12 (.clk, .reset, .we(we && wa == 4'd12), .d(wd), .bits(v[12]));
  register8 r13 (.clk, .reset, .we(we && wa == 4'd13), .d(wd), .bits(v[13]));
  register8 r14 (.clk, .reset, .we(we && wa == 4'd14), .d(wd), .bits(v[14]));
  register8 r15 (.clk, .reset, .we(we && wa == 4'd15), .d(wd), .bits(v[15]));
  assign qa = v[ra];
  assign qb = v[rb];
  assign qc = v[rc];
endmodule

// File: rtl/mlp_cpu_top.sv
// mlp_cpu_top: 8-bit CPU, unified 256-byte memory plus execution unit; ports clk, reset
module mlp_cpu_top (
  input logic clk,
  input logic reset
);
  mlp_cpu_if bus ();
  memory memory (.clk, .bus(bus));
  execution_unit u_exec (.clk, .reset, .bus(bus));
endmodule

// File: tb/tb_mlp_cpu_top.sv
// tb_mlp_cpu_top: directed programs preloaded into memory, checked against hand-computed results
module tb_mlp_cpu_top;
  import isa_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mlp_cpu_top dut (.clk(clk), .reset(reset));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.memory.memory[i] <= 8'h00;
  endtask
  task automatic poke(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1);
    dut.memory.memory[a] <= b0;
    dut.memory.memory[a + 8'd1] <= b1;
  endtask
  task automatic boot();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask
  initial begin
    run(1);
    clear_mem();
    boot();
    chk("rst_pc", dut.u_exec.pc, 16'h0);
    chk("rst_z", dut.u_exec.z, 16'h0);
    chk("rst_ir", dut.u_exec.ir, 16'h0);
    chk("rst_state", dut.u_exec.state, FETCH0);
    run(3);
    chk("nop_pc2", dut.u_exec.pc, 16'h2);
    run(3);
    chk("nop_pc4", dut.u_exec.pc, 16'h4);
    run(3 * 125);
    chk("nop_pcfe", dut.u_exec.pc, 16'hfe);
    run(3);
    chk("nop_wrap", dut.u_exec.pc, 16'h0);
    chk("nop_r5", dut.u_exec.registers.r5.bits, 16'h0);
    chk("nop_r15", dut.u_exec.registers.r15.bits, 16'h0);
    clear_mem();
    poke(8'h00, 8'h10, 8'h01);
    poke(8'h02, 8'h11, 8'h10);
    poke(8'h04, 8'h31, 8'h10);
    poke(8'h06, 8'h41, 8'h10);
    poke(8'h08, 8'h52, 8'h00);
    poke(8'h0a, 8'ha0, 8'h20);
    poke(8'h20, 8'hb0, 8'h40);
    poke(8'h22, 8'h84, 8'h10);
    poke(8'h24, 8'h55, 8'h01);
    poke(8'h26, 8'h13, 8'h55);
    poke(8'h28, 8'h66, 8'h10);
    poke(8'h2a, 8'h77, 8'h50);
    poke(8'h2c, 8'h28, 8'h10);
    poke(8'h2e, 8'hf0, 8'h00);
    boot();
    run(9);
    chk("movi_r0", dut.u_exec.registers.r0.bits, 16'h01);
    chk("movi_r1", dut.u_exec.registers.r1.bits, 16'h10);
    chk("store_m16", dut.memory.memory[16], 16'h10);
    chk("p_pc6", dut.u_exec.pc, 16'h6);
    run(3);
    chk("add_r1", dut.u_exec.registers.r1.bits, 16'h11);
    chk("add_z", dut.u_exec.z, 16'h0);
    run(3);
    chk("sub_r2", dut.u_exec.registers.r2.bits, 16'h00);
    chk("sub_z", dut.u_exec.z, 16'h1);
    run(3);
    chk("jz_pc", dut.u_exec.pc, 16'h20);
    run(3);
    chk("jnz_pc", dut.u_exec.pc, 16'h22);
    run(3);
    chk("xor_r4", dut.u_exec.registers.r4.bits, 16'h10);
    chk("xor_z", dut.u_exec.z, 16'h0);
    run(3);
    chk("sub_wrap_r5", dut.u_exec.registers.r5.bits, 16'hf0);
    run(3);
    chk("movi_r3", dut.u_exec.registers.r3.bits, 16'h55);
    chk("movi_z", dut.u_exec.z, 16'h0);
    run(3);
    chk("and_r6", dut.u_exec.registers.r6.bits, 16'h01);
    run(3);
    chk("or_r7", dut.u_exec.registers.r7.bits, 16'hf1);
    run(3);
    chk("load_r8", dut.u_exec.registers.r8.bits, 16'h10);
    run(3);
    chk("halt_state", dut.u_exec.state, HALTED);
    chk("halt_pc", dut.u_exec.pc, 16'h30);
    run(12);
    chk("halt_pc_frozen", dut.u_exec.pc, 16'h30);
    chk("halt_r8_frozen", dut.u_exec.registers.r8.bits, 16'h10);
    clear_mem();
    poke(8'h00, 8'h11, 8'h30);
    poke(8'h02, 8'h12, 8'haa);
    poke(8'h04, 8'h31, 8'h07);
    poke(8'h06, 8'h32, 8'h40);
    poke(8'h08, 8'hf0, 8'h00);
    poke(8'h40, 8'h11, 8'h11);
    boot();
    chk("rst_r1_cleared", dut.u_exec.registers.r1.bits, 16'h0);
    run(15);
    chk("smc_byte7", dut.memory.memory[7], 16'h30);
    chk("smc_m30", dut.memory.memory[8'h30], 16'haa);
    chk("smc_m40", dut.memory.memory[8'h40], 16'h11);
    clear_mem();
    poke(8'h00, 8'h11, 8'h77);
    poke(8'h02, 8'h31, 8'h50);
    poke(8'h50, 8'h99, 8'h00);
    boot();
    run(5);
    chk("mid_state", dut.u_exec.state, EXEC);
    chk("mid_r1", dut.u_exec.registers.r1.bits, 16'h77);
    reset = 1'b1;
    run(1);
    chk("mid_m50", dut.memory.memory[8'h50], 16'h99);
    chk("mid_pc", dut.u_exec.pc, 16'h0);
    chk("mid_r1_rst", dut.u_exec.registers.r1.bits, 16'h0);
    chk("mid_state_rst", dut.u_exec.state, FETCH0);
    reset = 1'b0;
    run(3);
    chk("restart_r1", dut.u_exec.registers.r1.bits, 16'h77);
    chk("restart_pc", dut.u_exec.pc, 16'h2);
    run(3);
    chk("restart_m50", dut.memory.memory[8'h50], 16'h77);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
